// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//   Elastic pipeline register for an inter-stage boundary (EX/MEM, MEM/WB, ...).
//   Holds up to two entries (main + skid) so that upstream sees a ready that
//   depends only on local state, never on the downstream ready, while still
//   sustaining one entry per cycle. Supports flush (bubble insertion) and
//   stall by backpressure. Reset is synchronous and active-high.
//
// Parameters
//   CTRL_W      width of the control field
//   DATA_W      width of the data field
//   CLEAR_DATA  1: data registers zeroed on flush and on drain-to-empty
//               0: data registers hold their last value
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      discard held entries and any concurrent input
//   in_valid_i   upstream entry valid
//   in_ready_o   stage can accept an entry this cycle
//   in_ctrl_i    upstream control field
//   in_data_i    upstream data field
//   out_valid_o  head entry valid
//   out_ready_i  downstream consumes head this cycle
//   out_ctrl_o   head control field, 0 when no valid head
//   out_data_o   head data field
//   occupancy_o  number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int CTRL_W     = 4,
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [CTRL_W-1:0] CTRL_ZERO = {CTRL_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic accept_s;
    logic drain_s;

    // Ready looks only at local state (and reset), keeping the upstream
    // handshake free of any combinational path from out_ready_i.
    assign in_ready_o  = !rst_i && (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    // A bubble must never carry control bits that could write state downstream.
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : CTRL_ZERO;
    assign out_data_o  = main_data_q;
    assign occupancy_o = state_q;

    assign accept_s = in_valid_i && in_ready_o;
    assign drain_s  = out_valid_o && out_ready_i;

    // Next-state and storage-update logic; all registers hold by default.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush_i) begin
            // Flush wins over any handshake; a concurrent input is dropped.
            state_d     = ST_EMPTY;
            main_data_d = CLEAR_DATA ? DATA_ZERO : main_data_q;
            skid_data_d = CLEAR_DATA ? DATA_ZERO : skid_data_q;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !drain_s) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                    end else if (accept_s && drain_s) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (drain_s) begin
                        state_d     = ST_EMPTY;
                        main_data_d = CLEAR_DATA ? DATA_ZERO : main_data_q;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // Skid entry moves up to become the new head.
                    if (drain_s) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a safe empty stage.
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_ZERO;
            main_data_q <= DATA_ZERO;
            skid_ctrl_q <= CTRL_ZERO;
            skid_data_q <= DATA_ZERO;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//   Directed vector table for reset, streaming, backpressure, flush, bubble
//   control and reset during TWO, followed by a randomized run against a
//   two-deep queue model including a ready-independence probe.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 32;

    logic              clk_i;
    logic              rst_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;

    pipe_skid_stage #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CLEAR_DATA(1'b0)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_ctrl_i  (in_ctrl_i),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_ctrl_o (out_ctrl_o),
        .out_data_o (out_data_o),
        .occupancy_o(occupancy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic              rst;
        logic              flush;
        logic              iv;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              ordy;
        logic              e_valid;
        logic [CTRL_W-1:0] e_ctrl;
        logic [DATA_W-1:0] e_data;
        logic [1:0]        e_occ;
        logic              e_irdy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [3:0] c,
                       input logic [31:0] d, input logic ordy, input logic ev,
                       input logic [3:0] ec, input logic [31:0] ed, input logic [1:0] eo,
                       input logic eir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ctrl = c; v.data = d; v.ordy = ordy;
        v.e_valid = ev; v.e_ctrl = ec; v.e_data = ed; v.e_occ = eo; v.e_irdy = eir;
        vecs.push_back(v);
    endtask

    logic [35:0] model_q[$];
    logic        exp_valid;
    logic        irdy_a;
    logic        irdy_b;
    logic        acc;
    logic        drn;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_ctrl_i = 4'h0; in_data_i = 32'h0;
        @(posedge clk_i);

        //  rst f  iv ctrl  data          ordy | valid ctrl  data          occ   irdy
        // T1 reset with in_valid_i high, then release
        add(1'b1,1'b0,1'b1,4'hF,32'h0000_00AA,1'b0, 1'b0,4'h0,32'h0000_0000,2'd0,1'b0);
        add(1'b1,1'b0,1'b1,4'hF,32'h0000_00AA,1'b0, 1'b0,4'h0,32'h0000_0000,2'd0,1'b0);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b0, 1'b0,4'h0,32'h0000_0000,2'd0,1'b1);
        // T2 streaming 1..4
        add(1'b0,1'b0,1'b1,4'h1,32'h0000_0001,1'b1, 1'b0,4'h0,32'h0000_0000,2'd0,1'b1);
        add(1'b0,1'b0,1'b1,4'h2,32'h0000_0002,1'b1, 1'b1,4'h1,32'h0000_0001,2'd1,1'b1);
        add(1'b0,1'b0,1'b1,4'h3,32'h0000_0003,1'b1, 1'b1,4'h2,32'h0000_0002,2'd1,1'b1);
        add(1'b0,1'b0,1'b1,4'h4,32'h0000_0004,1'b1, 1'b1,4'h3,32'h0000_0003,2'd1,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b1,4'h4,32'h0000_0004,2'd1,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b0,4'h0,32'h0000_0004,2'd0,1'b1);
        // T3 backpressure: 0x11, 0x22 fill, 0x33 held off
        add(1'b0,1'b0,1'b1,4'h5,32'h0000_0011,1'b0, 1'b0,4'h0,32'h0000_0004,2'd0,1'b1);
        add(1'b0,1'b0,1'b1,4'h6,32'h0000_0022,1'b0, 1'b1,4'h5,32'h0000_0011,2'd1,1'b1);
        add(1'b0,1'b0,1'b1,4'h7,32'h0000_0033,1'b0, 1'b1,4'h5,32'h0000_0011,2'd2,1'b0);
        add(1'b0,1'b0,1'b1,4'h7,32'h0000_0033,1'b1, 1'b1,4'h5,32'h0000_0011,2'd2,1'b0);
        add(1'b0,1'b0,1'b1,4'h7,32'h0000_0033,1'b1, 1'b1,4'h6,32'h0000_0022,2'd1,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b1,4'h7,32'h0000_0033,2'd1,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b0, 1'b0,4'h0,32'h0000_0033,2'd0,1'b1);
        // T4 flush from TWO with a concurrent input, then flush while EMPTY
        add(1'b0,1'b0,1'b1,4'hF,32'h0000_0044,1'b0, 1'b0,4'h0,32'h0000_0033,2'd0,1'b1);
        add(1'b0,1'b0,1'b1,4'hF,32'h0000_0055,1'b0, 1'b1,4'hF,32'h0000_0044,2'd1,1'b1);
        add(1'b0,1'b1,1'b1,4'hE,32'h0000_0066,1'b0, 1'b1,4'hF,32'h0000_0044,2'd2,1'b0);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b0,4'h0,32'h0000_0044,2'd0,1'b1);
        add(1'b0,1'b1,1'b1,4'h9,32'h0000_0077,1'b1, 1'b0,4'h0,32'h0000_0044,2'd0,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b0,4'h0,32'h0000_0044,2'd0,1'b1);
        // T5 bubble ctrl after carrying 4'b1011
        add(1'b0,1'b0,1'b1,4'hB,32'h0000_0088,1'b0, 1'b0,4'h0,32'h0000_0044,2'd0,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b1,4'hB,32'h0000_0088,2'd1,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b1, 1'b0,4'h0,32'h0000_0088,2'd0,1'b1);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b0, 1'b0,4'h0,32'h0000_0088,2'd0,1'b1);
        // Reset while in TWO with a pending drain
        add(1'b0,1'b0,1'b1,4'h1,32'h0000_0099,1'b0, 1'b0,4'h0,32'h0000_0088,2'd0,1'b1);
        add(1'b0,1'b0,1'b1,4'h2,32'h0000_00A0,1'b0, 1'b1,4'h1,32'h0000_0099,2'd1,1'b1);
        add(1'b1,1'b0,1'b1,4'h3,32'h0000_00B0,1'b1, 1'b1,4'h1,32'h0000_0099,2'd2,1'b0);
        add(1'b0,1'b0,1'b0,4'h0,32'h0000_0000,1'b0, 1'b0,4'h0,32'h0000_0000,2'd0,1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            rst_i = vecs[i].rst; flush_i = vecs[i].flush; in_valid_i = vecs[i].iv;
            in_ctrl_i = vecs[i].ctrl; in_data_i = vecs[i].data; out_ready_i = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d.out_valid", i), 64'(out_valid_o), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d.out_ctrl", i),  64'(out_ctrl_o),  64'(vecs[i].e_ctrl));
            check($sformatf("vec%0d.out_data", i),  64'(out_data_o),  64'(vecs[i].e_data));
            check($sformatf("vec%0d.occupancy", i), 64'(occupancy_o), 64'(vecs[i].e_occ));
            check($sformatf("vec%0d.in_ready", i),  64'(in_ready_o),  64'(vecs[i].e_irdy));
        end

        // Bring stage to a known empty state before the random run
        @(negedge clk_i);
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_q.delete();

        // T6 random run against a two-deep queue model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_i);
            in_valid_i  = ($urandom_range(0, 99) < 60);
            out_ready_i = ($urandom_range(0, 99) < 55);
            flush_i     = ($urandom_range(0, 99) < 4);
            in_ctrl_i   = 4'($urandom());
            in_data_i   = $urandom();
            #1;
            exp_valid = (model_q.size() != 0);
            check("rnd.occupancy", 64'(occupancy_o), 64'(model_q.size()));
            check("rnd.out_valid", 64'(out_valid_o), 64'(exp_valid));
            check("rnd.in_ready", 64'(in_ready_o), 64'(model_q.size() != 2));
            if (exp_valid) begin
                check("rnd.out_ctrl", 64'(out_ctrl_o), 64'(model_q[0][35:32]));
                check("rnd.out_data", 64'(out_data_o), 64'(model_q[0][31:0]));
            end else begin
                check("rnd.bubble_ctrl", 64'(out_ctrl_o), 64'h0);
            end
            // Probe: flipping out_ready_i must not move in_ready_o
            irdy_a = in_ready_o;
            out_ready_i = ~out_ready_i;
            #1;
            irdy_b = in_ready_o;
            out_ready_i = ~out_ready_i;
            #1;
            check("rnd.ready_indep", 64'(irdy_b), 64'(irdy_a));

            acc = in_valid_i && (model_q.size() != 2);
            drn = out_ready_i && (model_q.size() != 0);
            if (flush_i) begin
                model_q.delete();
            end else begin
                if (drn) void'(model_q.pop_front());
                if (acc) model_q.push_back({in_ctrl_i, in_data_i});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
